motor_array: RTL



---
 rtl/motor_array_if.sv | 13 +
 rtl/motor_array.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_array_if.sv
// Command/reply bus of the motor array: 4-bit tag plus 24-bit word in each
// direction, each qualified by a one-cycle write strobe.
interface motor_array_if;
    logic [3:0]  in_ctrl;
    logic [23:0] in_data;
    logic        in_wr;
    logic [3:0]  out_ctrl;
    logic [23:0] out_data;
    logic        out_wr;

    modport master (output in_ctrl, in_data, in_wr, input out_ctrl, out_data, out_wr);
    modport slave  (input in_ctrl, in_data, in_wr, output out_ctrl, out_data, out_wr);
endinterface

// File: rtl/motor_array.sv
// N-channel H-bridge driver: slew-limited duty ramp with safe reversal, brake,
// shared PWM counter, debounced encoder counters with queued overflow reports.
module motor_chan #(
    parameter int PWM_BITS  = 11,
    parameter int CNT_BITS  = 12,
    parameter int DEB_DELAY = 50000,
    parameter int RAMP_STEP = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                set,
    input  logic                brk,
    input  logic                stop,
    input  logic                rpt_clr,
    input  logic                dir_in,
    input  logic [PWM_BITS-1:0] tgt_in,
    input  logic                ppr,
    output logic                ina,
    output logic                inb,
    output logic                brake,
    output logic                ramping,
    output logic                pending,
    output logic [PWM_BITS-1:0] duty,
    output logic [CNT_BITS-1:0] cnt
);
    typedef enum logic [1:0] {R_IDLE, R_UP, R_DOWN, R_REV} ramp_e;

    localparam int DW = (DEB_DELAY > 1) ? $clog2(DEB_DELAY) : 1;
    localparam logic [DW-1:0]       DEB_LAST = DW'(DEB_DELAY - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(RAMP_STEP);

    logic [PWM_BITS-1:0] tgt, duty_nx;
    logic                dir_req, dir_out, dir_nx;
    ramp_e               mode;

    // The ramp state is implied by the duty/direction registers, so the
    // mode is classified combinationally and the registers are the state.
    always_comb begin
        mode    = R_IDLE;
        duty_nx = duty;
        dir_nx  = dir_out;
        if (dir_req != dir_out)  mode = R_REV;
        else if (tgt > duty)     mode = R_UP;
        else if (tgt < duty)     mode = R_DOWN;
        case (mode)
            R_UP:   duty_nx = (int'(tgt - duty) > RAMP_STEP) ? duty + STEP : tgt;
            R_DOWN: duty_nx = (int'(duty - tgt) > RAMP_STEP) ? duty - STEP : tgt;
            R_REV: begin
                duty_nx = (int'(duty) > RAMP_STEP) ? duty - STEP : '0;
                if (duty_nx == '0) dir_nx = dir_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty    <= '0;
            tgt     <= '0;
            dir_req <= 1'b0;
            dir_out <= 1'b0;
            brake   <= 1'b0;
        end else begin
            if (tick) begin
                duty    <= duty_nx;
                dir_out <= dir_nx;
            end
            if (set) begin
                tgt     <= tgt_in;
                dir_req <= dir_in;
                brake   <= 1'b0;
            end
            if (brk) begin
                duty  <= '0;
                tgt   <= '0;
                brake <= 1'b1;
            end
            if (stop) begin
                duty  <= '0;
                tgt   <= '0;
                brake <= 1'b0;
            end
        end
    end

    assign ramping = (mode != R_IDLE);
    assign ina     = brake | (dir_out & (|duty));
    assign inb     = brake | (~dir_out & (|duty));

    // Debouncer: the synchronised input must differ from the accepted level
    // for DEB_DELAY cycles; a one-cycle pulse marks each accepted rising edge.
    logic [1:0]    sync;
    logic          lvl, pulse;
    logic [DW-1:0] dcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            lvl   <= 1'b0;
            pulse <= 1'b0;
            dcnt  <= '0;
        end else begin
            sync  <= {sync[0], ppr};
            pulse <= 1'b0;
            if (sync[1] == lvl) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                lvl   <= sync[1];
                pulse <= sync[1];
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    logic clr;
    assign clr = set | stop | rpt_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            if (clr)                          cnt <= CNT_BITS'(pulse);
            else if (pulse && cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (rpt_clr)
                pending <= 1'b0;
            else if (!clr && pulse && cnt == CNT_MAX - 1'b1)
                pending <= 1'b1;
        end
    end
endmodule

module motor_array #(
    parameter int CHANNELS  = 2,
    parameter int PWM_BITS  = 11,
    parameter int CNT_BITS  = 12,
    parameter int DEB_DELAY = 50000,
    parameter int RAMP_DIV  = 1024,
    parameter int RAMP_STEP = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [CHANNELS-1:0] motor_ina,
    output logic [CHANNELS-1:0] motor_inb,
    output logic [CHANNELS-1:0] motor_pwm,
    input  logic [CHANNELS-1:0] ppr_sence,
    motor_array_if.slave        bus
);
    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [1:0] OP_SET = 2'b00, OP_BRAKE = 2'b10, OP_STOP = 2'b11;

    logic [PRE_W-1:0]    pre;
    logic [PWM_BITS-1:0] pcnt;
    logic                tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre  <= '0;
            pcnt <= '0;
        end else begin
            pre  <= tick ? '0 : pre + 1'b1;
            pcnt <= pcnt + 1'b1;
        end
    end
    assign tick = (pre == PRE_LAST);

    logic [1:0]          op, cmd_ch;
    logic                ch_ok, stop_all;
    logic [CHANNELS-1:0] set_v, brk_v, rpt_clr, brake, ramping, pending;
    logic [CHANNELS-1:0][PWM_BITS-1:0] duty;
    logic [CHANNELS-1:0][CNT_BITS-1:0] cnt;
    logic [1:0]          snap_stat, sel;
    logic [19:0]         snap_cnt;
    logic                any_pend, sel_ramp;
    logic                unused_bits;

    assign op          = bus.in_data[23:22];
    assign cmd_ch      = bus.in_data[21:20];
    assign unused_bits = ^bus.in_data[19:PWM_BITS+1];

    // Snapshot of the addressed channel; out-of-range channels read as 11/0.
    always_comb begin
        ch_ok     = 1'b0;
        snap_stat = 2'b11;
        snap_cnt  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cmd_ch == 2'(i)) begin
                ch_ok     = 1'b1;
                snap_stat = {ramping[i], pending[i]};
                snap_cnt  = 20'(cnt[i]);
            end
        end
    end

    // Lowest pending channel wins; a command reply in the same cycle defers it.
    always_comb begin
        any_pend = |pending;
        sel      = '0;
        sel_ramp = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel      = 2'(i);
                sel_ramp = ramping[i];
            end
        end
    end

    assign stop_all = bus.in_wr & ch_ok & (op == OP_STOP);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign set_v[i]   = bus.in_wr & ch_ok & (op == OP_SET)   & (cmd_ch == 2'(i));
        assign brk_v[i]   = bus.in_wr & ch_ok & (op == OP_BRAKE) & (cmd_ch == 2'(i));
        assign rpt_clr[i] = ~bus.in_wr & any_pend & (sel == 2'(i));
        assign motor_pwm[i] = ~brake[i] & (pcnt < duty[i]);

        motor_chan #(
            .PWM_BITS (PWM_BITS),
            .CNT_BITS (CNT_BITS),
            .DEB_DELAY(DEB_DELAY),
            .RAMP_STEP(RAMP_STEP)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .set    (set_v[i]),
            .brk    (brk_v[i]),
            .stop   (stop_all),
            .rpt_clr(rpt_clr[i]),
            .dir_in (bus.in_data[PWM_BITS]),
            .tgt_in (bus.in_data[PWM_BITS-1:0]),
            .ppr    (ppr_sence[i]),
            .ina    (motor_ina[i]),
            .inb    (motor_inb[i]),
            .brake  (brake[i]),
            .ramping(ramping[i]),
            .pending(pending[i]),
            .duty   (duty[i]),
            .cnt    (cnt[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_wr   <= 1'b0;
            bus.out_ctrl <= '0;
            bus.out_data <= '0;
        end else if (bus.in_wr) begin
            bus.out_wr   <= 1'b1;
            bus.out_ctrl <= bus.in_ctrl;
            bus.out_data <= {cmd_ch, snap_stat, snap_cnt};
        end else if (any_pend) begin
            bus.out_wr   <= 1'b1;
            bus.out_ctrl <= 4'hF;
            bus.out_data <= {sel, sel_ramp, 1'b1, 20'({CNT_BITS{1'b1}})};
        end else begin
            bus.out_wr <= 1'b0;
        end
    end
endmodule
